// File: rtl/encode_ucb_float_pipe_if.sv
// rtl/encode_ucb_float_pipe_if.sv - input/output handshake bundle for the binary64 to UCB recoded-float encoder
interface encode_ucb_float_pipe_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [64:0] out_data;
   logic        out_is_nan;
   logic        out_is_sub;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_is_nan, out_is_sub
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_is_nan, out_is_sub
   );
endinterface

// File: rtl/encode_ucb_float_pipe.sv
// rtl/encode_ucb_float_pipe.sv - 3-stage elastic binary64 to 65-bit UCB recoded-float encoder
// UCB_ENC_SUBNORMAL_EN: defined keeps subnormals (LZC + shifter); undefined flushes them to signed zero.
module encode_ucb_float_pipe (
   input  logic                   clk,
   input  logic                   reset,
   encode_ucb_float_pipe_if.slave bus
);
   logic        r1_valid, r1_sign, r1_exp_z, r1_fract_z, r1_exp_max;
   logic [10:0] r1_exp;
   logic [51:0] r1_fract;
   logic        r2_valid, r2_sign, r2_exp_z, r2_fract_z, r2_exp_max;
   logic [10:0] r2_exp;
   logic [51:0] r2_fract;
   logic        r3_valid, r3_is_nan, r3_is_sub;
   logic [64:0] r3_data;

   logic w_adv3, w_ld3, w_adv2, w_ld2, w_adv1, w_ld1;

   // Ready ripples back from out_ready only; in_valid never feeds in_ready.
   assign w_adv3 = r3_valid & bus.out_ready;
   assign w_ld3  = ~r3_valid | w_adv3;
   assign w_adv2 = r2_valid & w_ld3;
   assign w_ld2  = ~r2_valid | w_adv2;
   assign w_adv1 = r1_valid & w_ld2;
   assign w_ld1  = ~r1_valid | w_adv1;
   assign bus.in_ready = w_ld1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r1_valid <= 1'b0;
      end else if (w_ld1) begin
         r1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r1_sign    <= bus.in_data[63];
            r1_exp     <= bus.in_data[62:52];
            r1_fract   <= bus.in_data[51:0];
            r1_exp_z   <= (bus.in_data[62:52] == 11'h000);
            r1_fract_z <= (bus.in_data[51:0] == 52'h0);
            r1_exp_max <= (bus.in_data[62:52] == 11'h7FF);
         end
      end
   end

`ifdef UCB_ENC_SUBNORMAL_EN
   logic [5:0] w_norm_dist;
   logic [5:0] r2_norm_dist;

   // Last hit wins, so the result tracks the most significant set bit.
   always_comb begin
      w_norm_dist = 6'd0;
      for (int i = 0; i < 52; i++) begin
         if (r1_fract[i]) w_norm_dist = 6'(51 - i);
      end
   end

   always_ff @(posedge clk) begin
      if (w_ld2 && r1_valid) r2_norm_dist <= w_norm_dist;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r2_valid <= 1'b0;
      end else if (w_ld2) begin
         r2_valid <= r1_valid;
         if (r1_valid) begin
            r2_sign    <= r1_sign;
            r2_exp     <= r1_exp;
            r2_fract   <= r1_fract;
            r2_exp_z   <= r1_exp_z;
            r2_fract_z <= r1_fract_z;
            r2_exp_max <= r1_exp_max;
         end
      end
   end

   logic        w_is_sub, w_is_nan, w_zero;
   logic [11:0] w_adj_exp, w_rexp;
   logic [51:0] w_rsig;

   assign w_is_sub = r2_exp_z & ~r2_fract_z;
   assign w_is_nan = r2_exp_max & ~r2_fract_z;
`ifdef UCB_ENC_SUBNORMAL_EN
   logic [51:0] w_shift;
   assign w_shift = r2_fract << r2_norm_dist;
   assign w_zero  = r2_exp_z & r2_fract_z;
`else
   assign w_zero  = r2_exp_z;
`endif

   always_comb begin
      w_adj_exp = {1'b0, r2_exp} + 12'h401;
      w_rsig    = r2_fract;
`ifdef UCB_ENC_SUBNORMAL_EN
      if (w_is_sub) begin
         w_adj_exp = (~{6'b0, r2_norm_dist}) + 12'h402;
         w_rsig    = {w_shift[50:0], 1'b0};
      end
`else
      if (w_zero) w_rsig = 52'h0;
`endif
      if (w_zero)                         w_rexp = 12'h000;
      else if (r2_exp_max && r2_fract_z)  w_rexp = 12'hC00;
      else if (w_is_nan)                  w_rexp = 12'hE00;
      else                                w_rexp = w_adj_exp;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r3_valid  <= 1'b0;
         r3_data   <= 65'h0;
         r3_is_nan <= 1'b0;
         r3_is_sub <= 1'b0;
      end else if (w_ld3) begin
         r3_valid <= r2_valid;
         if (r2_valid) begin
            r3_data   <= {r2_sign, w_rexp, w_rsig};
            r3_is_nan <= w_is_nan;
            r3_is_sub <= w_is_sub;
         end
      end
   end

   assign bus.out_valid  = r3_valid;
   assign bus.out_data   = r3_data;
   assign bus.out_is_nan = r3_is_nan;
   assign bus.out_is_sub = r3_is_sub;
endmodule

// File: tb/tb_encode_ucb_float_pipe.sv
// tb/tb_encode_ucb_float_pipe.sv - self-checking bench for encode_ucb_float_pipe
module tb_encode_ucb_float_pipe;
   localparam int N_RAND = 10000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   encode_ucb_float_pipe_if bus();
   encode_ucb_float_pipe dut (.clk(clk), .reset(reset), .bus(bus));

   // Reference: {is_nan, is_sub, sign, rexp[11:0], rsig[51:0]} from the value's meaning.
   function automatic logic [66:0] ref_encode(input logic [63:0] d);
      logic s, nan, sub;
      logic [10:0] e;
      logic [51:0] f, rsig;
      logic [11:0] rexp;
      logic [63:0] t;
      int p;
      s = d[63]; e = d[62:52]; f = d[51:0];
      nan = (e == 11'h7FF) && (f != 0);
      sub = (e == 11'h0) && (f != 0);
      rsig = f;
      if (e == 11'h0 && f == 0) begin
         rexp = 12'h0;
      end else if (e == 11'h7FF) begin
         rexp = (f == 0) ? 12'hC00 : 12'hE00;
      end else if (e == 11'h0) begin
`ifdef UCB_ENC_SUBNORMAL_EN
         p = 0;
         for (int i = 0; i < 52; i++) if (f[i]) p = i;
         rexp = 12'(12'h3CE + p);
         t = {12'h0, f} << (52 - p);
         rsig = t[51:0];
`else
         rexp = 12'h0;
         rsig = 52'h0;
`endif
      end else begin
         rexp = 12'({1'b0, e} + 12'h401);
      end
      return {nan, sub, s, rexp, rsig};
   endfunction

   function automatic logic [63:0] ucb_decode(input logic [64:0] r);
      logic s;
      logic [11:0] re;
      logic [51:0] rs;
      logic [52:0] full;
      int e;
      s = r[64]; re = r[63:52]; rs = r[51:0];
      if (re[11:9] == 3'b000) return {s, 63'h0};
      if (re[11:9] == 3'b110) return {s, 11'h7FF, 52'h0};
      if (re[11:9] == 3'b111) return {s, 11'h7FF, rs};
      e = int'(re) - 'h401;
      if (e >= 1) return {s, 11'(e), rs};
      full = {1'b1, rs} >> (1 - e);
      return {s, 11'h0, full[51:0]};
   endfunction

   function automatic logic [63:0] gen_double();
      logic [63:0] d;
      d = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0: d[62:52] = 11'h0;
         1: begin d[62:52] = 11'h0; d[51:0] = 52'd1 << $urandom_range(0, 51); end
         2: d[62:52] = 11'h7FF;
         3: d[51:0] = 52'h0;
         4: begin d[62:52] = ($urandom_range(0, 1) != 0) ? 11'h7FF : 11'h0; d[51:0] = 52'h0; end
         default: ;
      endcase
      return d;
   endfunction

   task automatic drive(input logic v, input logic [63:0] d, input logic rdy);
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = rdy;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      drive(1'b0, 64'h0, 1'b0);
      drive(1'b0, 64'h0, 1'b0);
      reset = 1'b0;
      drive(1'b0, 64'h0, 1'b0);
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 65'h0 || bus.out_is_nan !== 1'b0 || bus.out_is_sub !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_outputs got v=%b d=%h n=%b s=%b want all zero", bus.out_valid, bus.out_data, bus.out_is_nan, bus.out_is_sub);
      end
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_directed;
      logic [63:0] vin[5];
      logic [64:0] vout[5];
      logic        vnan[5];
      int acc = 0, got = 0, first = -1;
      vin[0] = 64'h3FF0000000000000; vout[0] = 65'h0_8000000000000000; vnan[0] = 1'b0;
      vin[1] = 64'hC000000000000000; vout[1] = 65'h1_8010000000000000; vnan[1] = 1'b0;
      vin[2] = 64'h7FF0000000000000; vout[2] = 65'h0_C000000000000000; vnan[2] = 1'b0;
      vin[3] = 64'h7FF8000000000000; vout[3] = 65'h0_E008000000000000; vnan[3] = 1'b1;
      vin[4] = 64'h8000000000000000; vout[4] = 65'h1_0000000000000000; vnan[4] = 1'b0;
      for (int c = 0; c < 12; c++) begin
         drive(acc < 5, (acc < 5) ? vin[acc] : 64'h0, 1'b1);
         if (bus.out_valid) begin
            if (got == 0) first = c;
            if (got < 5) begin
               n_checks++;
               if (bus.out_data !== vout[got] || bus.out_is_nan !== vnan[got]) begin
                  n_errors++;
                  $display("FAIL directed_%0d got %h nan=%b want %h nan=%b", got, bus.out_data, bus.out_is_nan, vout[got], vnan[got]);
               end
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) acc++;
      end
      n_checks++;
      if (got != 5) begin n_errors++; $display("FAIL directed_count got %0d want 5", got); end
      n_checks++;
      if (first != 3) begin n_errors++; $display("FAIL directed_latency got %0d want 3", first); end
   endtask

   task automatic test_subnormal;
      logic [63:0] vin[3];
      logic [64:0] vout[3];
      logic        vsub[3];
      int acc = 0, got = 0;
      vin[0] = 64'h0000000000000001; vin[1] = 64'h800FFFFFFFFFFFFF; vin[2] = 64'h0010000000000000;
`ifdef UCB_ENC_SUBNORMAL_EN
      vout[0] = 65'h0_3CE0000000000000; vout[1] = 65'h1_401FFFFFFFFFFFFE;
`else
      vout[0] = 65'h0_0000000000000000; vout[1] = 65'h1_0000000000000000;
`endif
      vout[2] = 65'h0_4020000000000000;
      vsub[0] = 1'b1; vsub[1] = 1'b1; vsub[2] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         drive(acc < 3, (acc < 3) ? vin[acc] : 64'h0, 1'b1);
         if (bus.out_valid) begin
            if (got < 3) begin
               n_checks++;
               if (bus.out_data !== vout[got] || bus.out_is_sub !== vsub[got] || bus.out_is_nan !== 1'b0) begin
                  n_errors++;
                  $display("FAIL subnormal_%0d got %h sub=%b want %h sub=%b", got, bus.out_data, bus.out_is_sub, vout[got], vsub[got]);
               end
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) acc++;
      end
      n_checks++;
      if (got != 3) begin n_errors++; $display("FAIL subnormal_count got %0d want 3", got); end
   endtask

   task automatic test_backpressure;
      logic [63:0] vin[5];
      logic [66:0] e;
      logic [64:0] held = '0;
      logic        have_held = 1'b0;
      int idx = 0, got = 0, drop_cyc = -1;
      for (int i = 0; i < 5; i++) vin[i] = gen_double();
      for (int c = 0; c < 8; c++) begin
         drive(idx < 5, (idx < 5) ? vin[idx] : 64'h0, 1'b0);
         if (bus.in_ready === 1'b0 && drop_cyc < 0) drop_cyc = c;
         if (have_held) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
               n_errors++;
               $display("FAIL bp_stable got v=%b %h want v=1 %h", bus.out_valid, bus.out_data, held);
            end
         end else if (bus.out_valid) begin
            held = bus.out_data;
            have_held = 1'b1;
         end
         if (bus.in_valid && bus.in_ready) idx++;
      end
      n_checks++;
      if (idx != 3) begin n_errors++; $display("FAIL bp_accepted got %0d want 3", idx); end
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
      n_checks++;
      if (drop_cyc != 3) begin n_errors++; $display("FAIL bp_drop_cycle got %0d want 3", drop_cyc); end
      for (int c = 0; c < 20; c++) begin
         drive(idx < 5, (idx < 5) ? vin[idx] : 64'h0, 1'b1);
         if (bus.out_valid) begin
            if (got < 5) begin
               e = ref_encode(vin[got]);
               n_checks++;
               if (bus.out_data !== e[64:0] || bus.out_is_nan !== e[66] || bus.out_is_sub !== e[65]) begin
                  n_errors++;
                  $display("FAIL bp_out_%0d got %h want %h", got, bus.out_data, e[64:0]);
               end
            end
            got++;
         end
         if (bus.in_valid && bus.in_ready) idx++;
      end
      n_checks++;
      if (got != 5) begin n_errors++; $display("FAIL bp_out_count got %0d want 5", got); end
   endtask

   task automatic test_random;
      logic [66:0] exp_q[$];
      logic [63:0] in_q[$];
      logic [66:0] e;
      logic [63:0] src, cur = '0;
      logic [64:0] held = '0;
      logic v, rdy, pend = 1'b0, prev_stall = 1'b0;
      int got = 0, acc = 0, cyc = 0;
      while (got < N_RAND && cyc < 80000) begin
         if (!pend) begin
            v = (acc < N_RAND) && ($urandom_range(0, 3) != 0);
            cur = gen_double();
         end else begin
            v = 1'b1;
         end
         rdy = ($urandom_range(0, 3) != 0);
         drive(v, cur, rdy);
         cyc++;
         if (prev_stall) begin
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
               n_errors++;
               $display("FAIL rand_stall_hold got v=%b %h want v=1 %h", bus.out_valid, bus.out_data, held);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_errors++;
               $display("FAIL rand_unexpected got %h want no output", bus.out_data);
            end else begin
               e = exp_q.pop_front();
               src = in_q.pop_front();
               if (bus.out_data !== e[64:0] || bus.out_is_nan !== e[66] || bus.out_is_sub !== e[65]) begin
                  n_errors++;
                  $display("FAIL rand_out_%0d in %h got %h n=%b s=%b want %h n=%b s=%b", got, src,
                           bus.out_data, bus.out_is_nan, bus.out_is_sub, e[64:0], e[66], e[65]);
               end
`ifndef UCB_ENC_SUBNORMAL_EN
               if (!e[65]) begin
`else
               begin
`endif
                  n_checks++;
                  if (ucb_decode(bus.out_data) !== src) begin
                     n_errors++;
                     $display("FAIL rand_roundtrip got %h want %h", ucb_decode(bus.out_data), src);
                  end
               end
            end
            got++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         held = bus.out_data;
         pend = v && !bus.in_ready;
         if (v && bus.in_ready) begin
            exp_q.push_back(ref_encode(cur));
            in_q.push_back(cur);
            acc++;
         end
      end
      n_checks++;
      if (got != N_RAND) begin n_errors++; $display("FAIL rand_completion got %0d want %0d", got, N_RAND); end
      n_checks++;
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL rand_leftover got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_reset_midstream;
      int stale = 0;
      drive(1'b1, 64'h3FF0000000000000, 1'b1);
      drive(1'b1, 64'h4000000000000000, 1'b1);
      drive(1'b0, 64'h0, 1'b1);
      reset = 1'b1;
      drive(1'b0, 64'h0, 1'b1);
      reset = 1'b0;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== 65'h0 || bus.in_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL midreset_state got v=%b d=%h rdy=%b want v=0 d=0 rdy=1", bus.out_valid, bus.out_data, bus.in_ready);
      end
      for (int c = 0; c < 8; c++) begin
         drive(1'b0, 64'h0, 1'b1);
         if (bus.out_valid) stale++;
      end
      n_checks++;
      if (stale != 0) begin n_errors++; $display("FAIL midreset_stale got %0d want 0", stale); end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 64'h0;
      bus.out_ready = 1'b0;
      test_reset;
      test_directed;
      test_subnormal;
      test_backpressure;
      test_random;
      test_reset_midstream;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
